fb_write_arbiter: RTL and testbench
===================================

Name: fb_write_arbiter

Overview:
- Owns framebuffer write port A (fb_wea/fb_addra/fb_dina) and shares it between two requesters: a rasterizer pixel stream and a built-in hardware clear (fill) engine.
- Converts (x,y) to a linear RGB332 address at 320x240, drops off-screen pixels, and sweeps the whole buffer with one colour on request.
- Sits between the raster pipeline and the framebuffer; the VGA read side on port B is untouched.

Parameters:
- FB_W, 320, framebuffer width in pixels
- FB_H, 240, framebuffer height in pixels
- AW, 17, framebuffer address width
- CW, 8, pixel width (RGB332)

Ports:
- aclk  in  1  system clock, 100 MHz
- arstn  in  1  asynchronous active-low reset
- px_valid  in  1  raster pixel valid
- px_ready  out  1  arbiter accepts pixel this cycle
- px_x  in  9  pixel column
- px_y  in  8  pixel row
- px_color  in  CW  RGB332 colour
- clear_req  in  1  single-cycle pulse: fill entire buffer
- clear_color  in  CW  fill colour, sampled with clear_req
- clear_busy  out  1  clear sweep in progress
- clear_done  out  1  one-cycle pulse after last clear write
- fb_wea  out  1  framebuffer write enable
- fb_addra  out  AW  framebuffer write address
- fb_dina  out  CW  framebuffer write data

Behaviour:
- Clocking and reset: one clock, aclk; reset arstn is asynchronous, active-low.
- Reset values:
  - State = IDLE.
  - fb_wea = 0, fb_addra = 0, fb_dina = 0.
  - clear_busy = 0, clear_done = 0.
  - px_ready = 0 while arstn is low.
- FSM states: IDLE, CLEAR, DONE.
- IDLE, ready:
  - px_ready = 1 iff state == IDLE and clear_req == 0 (clear wins on the same cycle).
- IDLE, pixel accept:
  - A pixel transfers on px_valid & px_ready at cycle N.
  - At N+1, fb_wea = 1, fb_addra = px_y*FB_W + px_x, fb_dina = px_color.
  - Latency is 1 cycle; all port-A outputs are registered.
- Clipping:
  - A pixel with px_x >= FB_W or px_y >= FB_H is still accepted (handshake completes).
  - It gives fb_wea = 0 at N+1 and no write.
- Address arithmetic:
  - y*320 = (y<<8)+(y<<6), computed at AW bits.
  - Max in-range address 76799; no overflow possible.
- IDLE -> CLEAR on clear_req:
  - clear_color is latched into a fill register.
  - The address counter is cleared to 0.
  - clear_busy = 1 from the next cycle.
- CLEAR:
  - Each cycle: fb_wea = 1, fb_addra = counter, fb_dina = fill colour; counter increments.
  - Writes cover addresses 0..FB_W*FB_H-1 (76800 consecutive cycles).
  - px_ready = 0 throughout.
  - clear_req is ignored; the latched colour does not change.
- CLEAR -> DONE after the write of address 76799:
  - DONE lasts one cycle: fb_wea = 0, clear_done = 1, clear_busy = 0.
  - DONE -> IDLE unconditionally.
- Pipeline hazard: a pixel accepted on the cycle before clear_req still completes its write in the first cycle of CLEAR's transition. Ordering is pixel write, then clear writes starting at address 0.
- px_valid with px_ready = 0: the requester holds px_x/px_y/px_color stable; the arbiter does not sample them.
- Reset asserted mid-clear: the sweep aborts immediately, outputs return to reset values, and no clear_done is issued.

Optional Feature:
- FB_CLIP_COUNT_EN defined:
  - Adds output clip_count [15:0], a saturating count of accepted-but-clipped pixels.
  - Cleared by reset and by clear_req acceptance.
  - Saturates at 16'hFFFF.
- FB_CLIP_COUNT_EN undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package fb_pkg:
  - Constants FB_W, FB_H, FB_PIXELS (76800).
  - Typedefs rgb332_t (8-bit), fb_addr_t (17-bit).
  - Enum fb_arb_state_t {IDLE, CLEAR, DONE}.
- Sub-module fb_addr_calc: combinational shift-add x,y -> address plus an in_range flag. The arbiter registers its outputs.

Test Plan:
- Pixel (x=10, y=10, color 8'hE0) in IDLE -> one cycle later fb_wea=1, fb_addra=3210, fb_dina=8'hE0; px_ready stayed 1.
- Pixels (320,0) and (0,240) -> both handshake, fb_wea stays 0; with FB_CLIP_COUNT_EN, clip_count=2.
- clear_req with clear_color=8'h01 -> clear_busy high for 76800 cycles.
  - Writes addresses 0..76799 with data 8'h01.
  - clear_done pulses once; then IDLE with px_ready=1.
- px_valid held high across clear_req -> px_ready=0 from the clear_req cycle until DONE passes.
  - The held pixel is written after the sweep; no pixels are lost or duplicated.
- clear_req pulsed again mid-sweep with colour 8'hFF -> ignored; all writes remain 8'h01.
- arstn low at sweep address 40000 -> outputs return to reset values, no clear_done; after release, a pixel write succeeds normally.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants, types and state encoding for the framebuffer write arbiter.
package fb_pkg;

    localparam int unsigned FB_W      = 320;
    localparam int unsigned FB_H      = 240;
    localparam int unsigned FB_PIXELS = 76800;
    localparam int unsigned AW        = 17;
    localparam int unsigned CW        = 8;

    // Bounds and sweep length at the widths of the signals they are compared with.
    localparam logic [8:0]  FB_W_X      = 9'd320;
    localparam logic [7:0]  FB_H_Y      = 8'd240;
    localparam logic [16:0] FB_PIXELS_A = 17'd76800;

    typedef logic [7:0]  rgb332_t;
    typedef logic [16:0] fb_addr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } fb_arb_state_t;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational (x,y) -> linear framebuffer address, with an on-screen flag.
// The multiply by 320 is a shift-add: y*320 = (y<<8) + (y<<6).
module fb_addr_calc
    import fb_pkg::*;
(
    input  logic [8:0] x,
    input  logic [7:0] y,
    output fb_addr_t   addr,
    output logic       in_range
);

    fb_addr_t y_ext_s;
    fb_addr_t x_ext_s;

    assign y_ext_s  = {9'd0, y};
    assign x_ext_s  = {8'd0, x};
    assign addr     = (y_ext_s << 8) + (y_ext_s << 6) + x_ext_s;
    assign in_range = (x < FB_W_X) && (y < FB_H_Y);

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer port-A write arbiter: raster pixel stream vs. hardware clear sweep.
// Pixels write one cycle after their handshake; a clear fills every address
// with one latched colour, then pulses clear_done for one cycle.
// Optional build macro FB_CLIP_COUNT_EN adds a saturating clip_count output.
module fb_write_arbiter
    import fb_pkg::*;
(
    input  logic          aclk,
    input  logic          arstn,
    input  logic          px_valid,
    output logic          px_ready,
    input  logic [8:0]    px_x,
    input  logic [7:0]    px_y,
    input  logic [CW-1:0] px_color,
    input  logic          clear_req,
    input  logic [CW-1:0] clear_color,
    output logic          clear_busy,
    output logic          clear_done,
`ifdef FB_CLIP_COUNT_EN
    output logic [15:0]   clip_count,
`endif
    output logic          fb_wea,
    output logic [AW-1:0] fb_addra,
    output logic [CW-1:0] fb_dina
);

    fb_arb_state_t state_q, state_d;
    fb_addr_t      cnt_q, cnt_d;
    rgb332_t       fill_q, fill_d;
    logic          wea_q, wea_d;
    fb_addr_t      addr_q, addr_d;
    rgb332_t       din_q, din_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    fb_addr_t      px_addr_s;
    logic          px_in_range_s;

    fb_addr_calc u_addr_calc (
        .x        (px_x),
        .y        (px_y),
        .addr     (px_addr_s),
        .in_range (px_in_range_s)
    );

    // Clear has priority over a pixel offered in the same cycle; nothing is accepted in reset.
    assign px_ready = arstn && (state_q == IDLE) && !clear_req;

    // Next-state and next-output logic; the first clear write is set up on the request cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        wea_d   = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    fill_d  = clear_color;
                    cnt_d   = 17'd1;
                    wea_d   = 1'b1;
                    addr_d  = 17'd0;
                    din_d   = clear_color;
                    busy_d  = 1'b1;
                end else if (px_valid) begin
                    wea_d   = px_in_range_s;
                    addr_d  = px_addr_s;
                    din_d   = px_color;
                end else begin
                    wea_d   = 1'b0;
                end
            end
            CLEAR: begin
                if (cnt_q == FB_PIXELS_A) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    wea_d   = 1'b1;
                    addr_d  = cnt_q;
                    din_d   = fill_q;
                    cnt_d   = cnt_q + 17'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, sweep counter, fill colour and registered port-A / status outputs.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q <= IDLE;
            cnt_q   <= 17'd0;
            fill_q  <= 8'd0;
            wea_q   <= 1'b0;
            addr_q  <= 17'd0;
            din_q   <= 8'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fill_q  <= fill_d;
            wea_q   <= wea_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign fb_wea     = wea_q;
    assign fb_addra   = addr_q;
    assign fb_dina    = din_q;
    assign clear_busy = busy_q;
    assign clear_done = done_q;

`ifdef FB_CLIP_COUNT_EN
    logic [15:0] clip_q, clip_d;

    // Count accepted off-screen pixels, saturating; an accepted clear restarts the count.
    always_comb begin
        clip_d = clip_q;
        if ((state_q == IDLE) && clear_req) begin
            clip_d = 16'd0;
        end else if ((state_q == IDLE) && px_valid && !px_in_range_s && (clip_q != 16'hFFFF)) begin
            clip_d = clip_q + 16'd1;
        end else begin
            clip_d = clip_q;
        end
    end

    // Clip counter register.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            clip_q <= 16'd0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip_count = clip_q;
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: table of single-pixel vectors,
// then hand-written sequences for the clear sweep, hazards and reset abort.
module tb_fb_write_arbiter;

    logic        aclk;
    logic        arstn;
    logic        px_valid;
    logic        px_ready;
    logic [8:0]  px_x;
    logic [7:0]  px_y;
    logic [7:0]  px_color;
    logic        clear_req;
    logic [7:0]  clear_color;
    logic        clear_busy;
    logic        clear_done;
    logic        fb_wea;
    logic [16:0] fb_addra;
    logic [7:0]  fb_dina;
`ifdef FB_CLIP_COUNT_EN
    logic [15:0] clip_count;
`endif

    int tests_run;
    int tests_failed;

    fb_write_arbiter dut (
        .aclk        (aclk),
        .arstn       (arstn),
        .px_valid    (px_valid),
        .px_ready    (px_ready),
        .px_x        (px_x),
        .px_y        (px_y),
        .px_color    (px_color),
        .clear_req   (clear_req),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
`ifdef FB_CLIP_COUNT_EN
        .clip_count  (clip_count),
`endif
        .fb_wea      (fb_wea),
        .fb_addra    (fb_addra),
        .fb_dina     (fb_dina)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct packed {
        logic        valid;
        logic [8:0]  x;
        logic [7:0]  y;
        logic [7:0]  color;
        logic        exp_wea;
        logic [16:0] exp_addr;
    } vec_t;

    vec_t vecs [0:8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    initial begin
        int errs;
        int clipped;
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{1'b1, 9'd10,  8'd10,  8'hE0, 1'b1, 17'd3210};
        vecs[1] = '{1'b1, 9'd0,   8'd0,   8'h55, 1'b1, 17'd0};
        vecs[2] = '{1'b1, 9'd319, 8'd239, 8'hAA, 1'b1, 17'd76799};
        vecs[3] = '{1'b1, 9'd320, 8'd0,   8'h11, 1'b0, 17'd0};
        vecs[4] = '{1'b1, 9'd0,   8'd240, 8'h22, 1'b0, 17'd0};
        vecs[5] = '{1'b1, 9'd5,   8'd1,   8'h3C, 1'b1, 17'd325};
        vecs[6] = '{1'b0, 9'd3,   8'd3,   8'h77, 1'b0, 17'd0};
        vecs[7] = '{1'b1, 9'd511, 8'd255, 8'h33, 1'b0, 17'd0};
        vecs[8] = '{1'b1, 9'd100, 8'd200, 8'h0F, 1'b1, 17'd64100};

        arstn       = 1'b0;
        px_valid    = 1'b1;
        px_x        = 9'd1;
        px_y        = 8'd1;
        px_color    = 8'h00;
        clear_req   = 1'b0;
        clear_color = 8'h00;

        // Reset state, with a pixel offered during reset.
        #12;
        chk("rst_wea",   fb_wea,     1'b0);
        chk("rst_addr",  fb_addra,   17'd0);
        chk("rst_din",   fb_dina,    8'h00);
        chk("rst_busy",  clear_busy, 1'b0);
        chk("rst_done",  clear_done, 1'b0);
        chk("rst_ready", px_ready,   1'b0);
        px_valid = 1'b0;
        arstn    = 1'b1;
        step();

        // Single-pixel vectors.
        clipped = 0;
        for (int i = 0; i < 9; i++) begin
            px_valid = vecs[i].valid;
            px_x     = vecs[i].x;
            px_y     = vecs[i].y;
            px_color = vecs[i].color;
            #1;
            chk($sformatf("vec%0d_ready", i), px_ready, 1'b1);
            step();
            chk($sformatf("vec%0d_wea", i), fb_wea, vecs[i].exp_wea);
            if (vecs[i].exp_wea) begin
                chk($sformatf("vec%0d_addr", i), fb_addra, vecs[i].exp_addr);
                chk($sformatf("vec%0d_din", i), fb_dina, vecs[i].color);
            end else begin
                if (vecs[i].valid) clipped++;
            end
        end
`ifdef FB_CLIP_COUNT_EN
        chk("clip_count_table", clip_count, 32'(clipped));
`endif

        // Pixel accepted the cycle before clear_req writes first, then the sweep starts at 0.
        px_valid = 1'b1;
        px_x     = 9'd20;
        px_y     = 8'd2;
        px_color = 8'hC3;
        #1;
        chk("haz_ready", px_ready, 1'b1);
        step();
        px_valid    = 1'b0;
        clear_req   = 1'b1;
        clear_color = 8'h5A;
        #1;
        chk("haz_ready_clr", px_ready, 1'b0);
        chk("haz_px_wea",    fb_wea,   1'b1);
        chk("haz_px_addr",   fb_addra, 17'd660);
        chk("haz_px_din",    fb_dina,  8'hC3);
        step();
        clear_req = 1'b0;
        chk("haz_busy",     clear_busy, 1'b1);
        chk("haz_clr_wea",  fb_wea,     1'b1);
        chk("haz_clr_addr", fb_addra,   17'd0);
        chk("haz_clr_din",  fb_dina,    8'h5A);
`ifdef FB_CLIP_COUNT_EN
        chk("clip_cleared", clip_count, 16'd0);
`endif
        errs = 0;
        for (int i = 0; i < 1000; i++) begin
            if (fb_wea !== 1'b1 || fb_addra !== 17'(i) || fb_dina !== 8'h5A ||
                clear_busy !== 1'b1 || clear_done !== 1'b0) errs++;
            step();
        end
        chk("part_sweep_errs", errs, 0);
        chk("part_sweep_addr", fb_addra, 17'd1000);

        // Reset in mid-sweep aborts it.
        arstn = 1'b0;
        #1;
        chk("abort_wea",   fb_wea,     1'b0);
        chk("abort_addr",  fb_addra,   17'd0);
        chk("abort_din",   fb_dina,    8'h00);
        chk("abort_busy",  clear_busy, 1'b0);
        chk("abort_ready", px_ready,   1'b0);
        step();
        step();
        arstn = 1'b1;
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (clear_done !== 1'b0 || fb_wea !== 1'b0 || clear_busy !== 1'b0) errs++;
        end
        chk("abort_no_done", errs, 0);
        px_valid = 1'b1;
        px_x     = 9'd10;
        px_y     = 8'd10;
        px_color = 8'hE0;
        #1;
        chk("post_rst_ready", px_ready, 1'b1);
        step();
        px_valid = 1'b0;
        chk("post_rst_wea",  fb_wea,   1'b1);
        chk("post_rst_addr", fb_addra, 17'd3210);
        chk("post_rst_din",  fb_dina,  8'hE0);

        // Full sweep with a pixel held across it and a second clear_req mid-sweep.
        px_valid    = 1'b1;
        px_x        = 9'd7;
        px_y        = 8'd3;
        px_color    = 8'h99;
        clear_req   = 1'b1;
        clear_color = 8'h01;
        #1;
        chk("full_ready_clr", px_ready, 1'b0);
        step();
        clear_req = 1'b0;
        errs = 0;
        for (int i = 0; i < 76800; i++) begin
            if (fb_wea !== 1'b1 || fb_addra !== 17'(i) || fb_dina !== 8'h01 ||
                clear_busy !== 1'b1 || clear_done !== 1'b0 || px_ready !== 1'b0) errs++;
            clear_req   = (i == 30000);
            clear_color = (i == 30000) ? 8'hFF : 8'h01;
            step();
        end
        chk("full_sweep_errs", errs, 0);
        chk("done_pulse",  clear_done, 1'b1);
        chk("done_wea",    fb_wea,     1'b0);
        chk("done_busy",   clear_busy, 1'b0);
        chk("done_ready",  px_ready,   1'b0);
        step();
        chk("idle_ready",   px_ready,   1'b1);
        chk("done_cleared", clear_done, 1'b0);
        step();
        px_valid = 1'b0;
        chk("held_wea",  fb_wea,   1'b1);
        chk("held_addr", fb_addra, 17'd967);
        chk("held_din",  fb_dina,  8'h99);
        step();
        chk("held_no_dup", fb_wea, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
